// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Two-requester arbiter sharing one external ALU with fixed latency.
//            Define ALU_ARBITER_RR_EN for round-robin contention, else req0 wins.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [3:0]  req0_aluop,
    input  logic [3:0]  req1_aluop,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [3:0]  alu_aluop,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_result,
    output logic        rsp_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic [3:0]  aluop_q, aluop_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] res_q, res_d;
    logic        zero_q, zero_d;
    logic        rsp0_q, rsp0_d;
    logic        rsp1_q, rsp1_d;

    logic        pick1;
    logic        in_idle;
    logic        gnt0;
    logic        gnt1;
    logic        capture;

    // Contention winner: requester 1 only when it did not win the last grant.
`ifdef ALU_ARBITER_RR_EN
    assign pick1 = ~last_grant_q;
`else
    assign pick1 = 1'b0;
`endif

    assign in_idle    = (state_q == IDLE) && rst_n;
    assign gnt0       = in_idle && req0_valid && (!req1_valid || !pick1);
    assign gnt1       = in_idle && req1_valid && (!req0_valid || pick1);
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign capture    = (state_q == EXEC) && (cnt_q == 4'd0);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        aluop_d      = aluop_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        zero_d       = zero_q;
        rsp0_d       = 1'b0;
        rsp1_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    state_d      = EXEC;
                    cnt_d        = LAT_M1;
                    last_grant_d = gnt1;
                    aluop_d      = gnt1 ? req1_aluop : req0_aluop;
                    a_d          = gnt1 ? req1_a     : req0_a;
                    b_d          = gnt1 ? req1_b     : req0_b;
                end
            end
            EXEC: begin
                if (capture) begin
                    state_d = RESP;
                    res_d   = alu_result;
                    zero_d  = alu_zero;
                    rsp0_d  = ~last_grant_q;
                    rsp1_d  = last_grant_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
            aluop_q      <= 4'd0;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            res_q        <= 32'd0;
            zero_q       <= 1'b0;
            rsp0_q       <= 1'b0;
            rsp1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            aluop_q      <= aluop_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            zero_q       <= zero_d;
            rsp0_q       <= rsp0_d;
            rsp1_q       <= rsp1_d;
        end
    end

    assign alu_aluop  = aluop_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp_result = res_q;
    assign rsp_zero   = zero_q;
    assign rsp0_valid = rsp0_q;
    assign rsp1_valid = rsp1_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Scoreboard bench for alu_arbiter (ALU_LAT=1 and ALU_LAT=3 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        r0v = 1'b0, r1v = 1'b0;
    logic [3:0]  r0op = 4'd0, r1op = 4'd0;
    logic [31:0] r0a = 32'd0, r0b = 32'd0, r1a = 32'd0, r1b = 32'd0;
    logic        r0rdy, r1rdy;
    logic [3:0]  aluop;
    logic [31:0] alua, alub, alures;
    logic        aluz;
    logic        rsp0v, rsp1v, rspz;
    logic [31:0] rspres;

    assign alures = alua + alub;
    assign aluz   = (alures == 32'd0);

    alu_arbiter #(.ALU_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req1_valid(r1v),
        .req0_ready(r0rdy), .req1_ready(r1rdy),
        .req0_aluop(r0op), .req1_aluop(r1op),
        .req0_a(r0a), .req0_b(r0b), .req1_a(r1a), .req1_b(r1b),
        .alu_aluop(aluop), .alu_a(alua), .alu_b(alub),
        .alu_result(alures), .alu_zero(aluz),
        .rsp0_valid(rsp0v), .rsp1_valid(rsp1v),
        .rsp_result(rspres), .rsp_zero(rspz)
    );

    logic        r0v3 = 1'b0;
    logic        r1v3 = 1'b0;
    logic [3:0]  op3 = 4'd0;
    logic [31:0] a3 = 32'd0, b3 = 32'd0, zero32 = 32'd0;
    logic        r0rdy3, r1rdy3;
    logic [3:0]  aluop3;
    logic [31:0] alua3, alub3, alures3;
    logic        aluz3;
    logic        rsp0v3, rsp1v3, rspz3;
    logic [31:0] rspres3;

    assign alures3 = alua3 + alub3;
    assign aluz3   = (alures3 == 32'd0);

    alu_arbiter #(.ALU_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v3), .req1_valid(r1v3),
        .req0_ready(r0rdy3), .req1_ready(r1rdy3),
        .req0_aluop(op3), .req1_aluop(op3),
        .req0_a(a3), .req0_b(b3), .req1_a(zero32), .req1_b(zero32),
        .alu_aluop(aluop3), .alu_a(alua3), .alu_b(alub3),
        .alu_result(alures3), .alu_zero(aluz3),
        .rsp0_valid(rsp0v3), .rsp1_valid(rsp1v3),
        .rsp_result(rspres3), .rsp_zero(rspz3)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          id;
        logic [31:0] res;
        logic        z;
        int          cyc;
    } exp_t;
    exp_t q[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every response strobe consumes one expectation.
    always @(negedge clk) begin
        if (rsp0v || rsp1v) begin
            if (q.size() == 0) begin
                check1("unexpected_rsp", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check1("rsp0_valid", rsp0v, !e.id);
                check1("rsp1_valid", rsp1v, e.id);
                check32("rsp_result", rspres, e.res);
                check1("rsp_zero", rspz, e.z);
                check32("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_ready(input bit id, output int acc);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (id ? r1rdy : r0rdy) break;
            n++;
            if (n > 50) begin
                check1("ready_timeout", 1'b0, 1'b1);
                break;
            end
        end
        acc = cyc;
    endtask

    task automatic push(input bit id, input logic [31:0] res, input logic z, input int c);
        exp_t e;
        e.id = id; e.res = res; e.z = z; e.cyc = c;
        q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc1, rel, n, seen;

        // Reset: outputs at reset values, ready held low despite a request.
        r0v = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check1("reset_ready0", r0rdy, 1'b0);
        check32("reset_alu_a", alua, 32'd0);
        check32("reset_rsp_result", rspres, 32'd0);
        check1("reset_rsp0_valid", rsp0v, 1'b0);
        r0v = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        // Single req0: 5 + 3 = 8.
        r0v = 1'b1; r0op = 4'd0; r0a = 32'h5; r0b = 32'h3;
        wait_ready(0, acc);
        push(0, 32'h8, 1'b0, acc + 2);
        @(posedge clk); #1 r0v = 1'b0;
        @(negedge clk);
        check32("alu_a_driven", alua, 32'h5);
        check32("alu_b_driven", alub, 32'h3);
        repeat (3) @(posedge clk); #1;

        // Single req1 wrap-around: FFFFFFFF + 1 = 0, zero set.
        r1v = 1'b1; r1op = 4'd1; r1a = 32'hFFFF_FFFF; r1b = 32'h1;
        wait_ready(1, acc);
        push(1, 32'h0, 1'b1, acc + 2);
        @(posedge clk); #1 r1v = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Contention for four operations.
        r0v = 1'b1; r0a = 32'd10; r0b = 32'd1;
        r1v = 1'b1; r1a = 32'd20; r1b = 32'd2;
        n = 0;
        forever begin
            @(negedge clk);
            if (r0rdy || r1rdy) break;
            n++;
            if (n > 50) begin check1("contend_timeout", 1'b0, 1'b1); break; end
        end
        acc = cyc;
        check1("first_contention_req0", r0rdy, 1'b1);
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARBITER_RR_EN
            if (i % 2 == 1) push(1, 32'd22, 1'b0, acc + 2 + 3 * i);
            else            push(0, 32'd11, 1'b0, acc + 2 + 3 * i);
`else
            push(0, 32'd11, 1'b0, acc + 2 + 3 * i);
`endif
        end
        seen = 0;
        n = 0;
        while (seen < 4 && n < 60) begin
            @(negedge clk);
            if (rsp0v || rsp1v) seen++;
            n++;
        end
        r0v = 1'b0; r1v = 1'b0;
        check32("contention_rsp_count", seen, 32'd4);
        repeat (3) @(posedge clk); #1;

        // req0 arriving while req1 executes: held off until IDLE.
        r1v = 1'b1; r1a = 32'd7; r1b = 32'd9;
        wait_ready(1, acc1);
        push(1, 32'd16, 1'b0, acc1 + 2);
        @(posedge clk); #1 r1v = 1'b0;
        r0v = 1'b1; r0a = 32'h100; r0b = 32'h23;
        @(negedge clk);
        check1("late_req_ready_exec", r0rdy, 1'b0);
        @(negedge clk);
        check1("late_req_ready_resp", r0rdy, 1'b0);
        wait_ready(0, acc);
        check32("late_req_accept_cyc", acc, acc1 + 3);
        push(0, 32'h123, 1'b0, acc + 2);
        @(posedge clk); #1 r0v = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Reset during EXEC drops req0's operation; pending req1 goes next.
        r0v = 1'b1; r0a = 32'h1; r0b = 32'h2;
        wait_ready(0, acc);
        @(posedge clk); #1 r0v = 1'b0;
        r1v = 1'b1; r1a = 32'h40; r1b = 32'h2;
        #2 rst_n = 1'b0;
        #1;
        check1("rst_rsp0_valid", rsp0v, 1'b0);
        check32("rst_alu_a", alua, 32'd0);
        check32("rst_alu_aluop", {28'd0, aluop}, 32'd0);
        check32("rst_rsp_result", rspres, 32'd0);
        check1("rst_rsp_zero", rspz, 1'b0);
        check1("rst_ready1", r1rdy, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        rel = cyc;
        wait_ready(1, acc);
        check32("post_reset_accept_cyc", acc, rel);
        push(1, 32'h42, 1'b0, acc + 2);
        @(posedge clk); #1 r1v = 1'b0;
        repeat (4) @(posedge clk); #1;

        // ALU_LAT=3 instance: 2 + 3 = 5, accept at k, rsp at k+4, next accept k+5.
        r0v3 = 1'b1; a3 = 32'd2; b3 = 32'd3;
        n = 0;
        forever begin
            @(negedge clk);
            if (r0rdy3) break;
            n++;
            if (n > 50) begin check1("lat3_timeout", 1'b0, 1'b1); break; end
        end
        @(posedge clk); #1 a3 = 32'd10; b3 = 32'd20;
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) @(posedge clk);
            @(negedge clk);
            check1("lat3_ready_low", r0rdy3, 1'b0);
            check1("lat3_rsp0_valid", rsp0v3, (i == 4));
            if (i == 4) check32("lat3_rsp_result", rspres3, 32'd5);
        end
        @(negedge clk);
        check1("lat3_next_accept", r0rdy3, 1'b1);
        @(posedge clk); #1 r0v3 = 1'b0;

        repeat (8) @(negedge clk);
        check32("scoreboard_empty", q.size(), 32'd0);
        check1("rsp1_lat3_never", rsp1v3, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
